ext_mem_responder: RTL and testbench

- Responder end of the core's external memory burst interface. The MMU/memory arbiter is the initiator; this block accepts its read and write bursts of 1–4 beats of 128 bits.
- Backed by a synchronous SRAM array.
- Returns read beats with per-beat acks and a single write ack per burst.
- Serves as the on-chip memory model for core-level simulation and as the template for the real memory controller front end.

---
 rtl/ext_mem_responder_if.sv | 38 +++
 rtl/ext_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_ext_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_responder_if.sv
// External memory burst bus between the MMU/memory arbiter (master) and the
// memory responder (slave). Carries request, write-beat and response signals.
interface ext_mem_responder_if #(
   parameter int PADDR_WIDTH = 34,
   parameter int DATA_WIDTH  = 128,
   parameter int MASK_WIDTH  = 16
) ();
   logic                   i_mem_ext_rden;
   logic                   i_mem_ext_wren;
   logic [PADDR_WIDTH-1:0] i_mem_ext_paddr;
   logic [2:0]             i_mem_ext_burst;
   logic                   i_mem_ext_burst_vld;
   logic                   i_mem_ext_burst_start;
   logic                   i_mem_ext_burst_end;
   logic [MASK_WIDTH-1:0]  i_mem_ext_mask;
   logic [DATA_WIDTH-1:0]  i_mem_ext_wdat;
   logic                   o_ext_mmu_rdy;
   logic                   o_ext_mmu_rd_ack;
   logic [DATA_WIDTH-1:0]  o_ext_mmu_rdat;
   logic                   o_ext_mmu_wr_ack;
   logic                   o_ext_mem_err;

   modport master (
      output i_mem_ext_rden, i_mem_ext_wren, i_mem_ext_paddr, i_mem_ext_burst,
             i_mem_ext_burst_vld, i_mem_ext_burst_start, i_mem_ext_burst_end,
             i_mem_ext_mask, i_mem_ext_wdat,
      input  o_ext_mmu_rdy, o_ext_mmu_rd_ack, o_ext_mmu_rdat, o_ext_mmu_wr_ack,
             o_ext_mem_err
   );

   modport slave (
      input  i_mem_ext_rden, i_mem_ext_wren, i_mem_ext_paddr, i_mem_ext_burst,
             i_mem_ext_burst_vld, i_mem_ext_burst_start, i_mem_ext_burst_end,
             i_mem_ext_mask, i_mem_ext_wdat,
      output o_ext_mmu_rdy, o_ext_mmu_rd_ack, o_ext_mmu_rdat, o_ext_mmu_wr_ack,
             o_ext_mem_err
   );
endinterface

// File: rtl/ext_mem_responder.sv
// Responder end of the external memory burst interface. Accepts read/write
// bursts of 1..4 128-bit beats into a synchronous SRAM array, returns read
// beats with per-beat acks after a fixed latency and a single ack per write.
module ext_mem_responder #(
   parameter int PADDR_WIDTH = 34,
   parameter int DATA_WIDTH  = 128,
   parameter int MASK_WIDTH  = 16,
   parameter int DEPTH_LOG2  = 10,
   parameter int RD_LATENCY  = 2
) (
   input logic              clk,
   input logic              rst,
   ext_mem_responder_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_t;

   state_t                 state_reg, state_next;
   logic [DEPTH_LOG2-1:0]  base_idx_reg, base_idx_next;
   logic [1:0]             last_beat_reg, last_beat_next;
   logic [1:0]             beat_cnt_reg, beat_cnt_next;
   logic [2:0]             wait_cnt_reg, wait_cnt_next;
   logic                   err_reg, err_next;
   logic                   rd_ack_reg;
   logic [DATA_WIDTH-1:0]  rdat_reg;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [DEPTH_LOG2-1:0]  req_idx;
   logic [1:0]             req_last;
   logic                   req_illegal;
   logic                   ram_we;
   logic [DEPTH_LOG2-1:0]  wr_idx;
   logic                   rd_en;
   logic [DEPTH_LOG2-1:0]  rd_idx;
   logic                   beat_is_last;
   logic                   proto_bad;
   logic [MASK_WIDTH-1:0]  byte_we;

   // Byte offset and address bits above the array are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_mem_ext_paddr[3:0],
                               bus.i_mem_ext_paddr[PADDR_WIDTH-1:DEPTH_LOG2+4]};

   assign req_idx = bus.i_mem_ext_paddr[DEPTH_LOG2+3:4];

   // Burst code decode: 0 runs as one beat, 5..7 run as four; both flag err.
   always_comb begin
      req_last    = 2'd0;
      req_illegal = (bus.i_mem_ext_burst == 3'd0) || (bus.i_mem_ext_burst > 3'd4);
      case (bus.i_mem_ext_burst)
         3'd2:    req_last = 2'd1;
         3'd3:    req_last = 2'd2;
         3'd4, 3'd5, 3'd6, 3'd7: req_last = 2'd3;
         default: req_last = 2'd0;
      endcase
   end

   // Next-state logic: accept arbitration, write beat tracking, read issue timing.
   // A RAM read is issued one cycle before the matching rd_ack cycle.
   always_comb begin
      state_next     = state_reg;
      base_idx_next  = base_idx_reg;
      last_beat_next = last_beat_reg;
      beat_cnt_next  = beat_cnt_reg;
      wait_cnt_next  = wait_cnt_reg;
      err_next       = err_reg;
      ram_we         = 1'b0;
      rd_en          = 1'b0;
      rd_idx         = base_idx_reg;
      wr_idx         = base_idx_reg + DEPTH_LOG2'(beat_cnt_reg);
      beat_is_last   = (beat_cnt_reg == last_beat_reg);
      proto_bad      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.i_mem_ext_wren || bus.i_mem_ext_rden) begin
               base_idx_next  = req_idx;
               last_beat_next = req_last;
               beat_cnt_next  = 2'd0;
               wait_cnt_next  = 3'd0;
               if (req_illegal) err_next = 1'b1;
               if (bus.i_mem_ext_wren) begin
                  // Write wins a simultaneous request; the read stays pending.
                  state_next = WR_DATA;
               end else if (RD_LATENCY == 1) begin
                  state_next = RD_DATA;
                  rd_en      = 1'b1;
                  rd_idx     = req_idx;
               end else begin
                  state_next = RD_WAIT;
               end
            end
         end
         WR_DATA: begin
            if (bus.i_mem_ext_burst_vld) begin
               ram_we        = 1'b1;
               beat_cnt_next = beat_cnt_reg + 2'd1;
               proto_bad = (bus.i_mem_ext_burst_start != (beat_cnt_reg == 2'd0)) ||
                           (bus.i_mem_ext_burst_end != beat_is_last);
               if (proto_bad) err_next = 1'b1;
               if (beat_is_last) state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            state_next = IDLE;
         end
         RD_WAIT: begin
            wait_cnt_next = wait_cnt_reg + 3'd1;
            if (wait_cnt_reg == 3'(RD_LATENCY - 2)) begin
               state_next = RD_DATA;
               rd_en      = 1'b1;
               rd_idx     = base_idx_reg;
            end
         end
         RD_DATA: begin
            beat_cnt_next = beat_cnt_reg + 2'd1;
            if (beat_is_last) begin
               state_next = IDLE;
            end else begin
               rd_en  = 1'b1;
               rd_idx = base_idx_reg + DEPTH_LOG2'(beat_cnt_reg) + DEPTH_LOG2'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         base_idx_reg  <= '0;
         last_beat_reg <= 2'd0;
         beat_cnt_reg  <= 2'd0;
         wait_cnt_reg  <= 3'd0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         base_idx_reg  <= base_idx_next;
         last_beat_reg <= last_beat_next;
         beat_cnt_reg  <= beat_cnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         err_reg       <= err_next;
      end
   end

   // Per-byte write enables for the merged write.
   generate
      for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_byte_we
         assign byte_we[gi] = ram_we & bus.i_mem_ext_mask[gi] & ~rst;
      end
   endgenerate

   // RAM write port, byte-merged; contents are never reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
         if (byte_we[b]) mem[wr_idx][8*b +: 8] <= bus.i_mem_ext_wdat[8*b +: 8];
      end
   end

   // Registered RAM read port; data is forced to zero outside ack cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ack_reg <= 1'b0;
         rdat_reg   <= '0;
      end else begin
         rd_ack_reg <= rd_en;
         rdat_reg   <= rd_en ? mem[rd_idx] : '0;
      end
   end

   assign bus.o_ext_mmu_rdy    = (state_reg == IDLE);
   assign bus.o_ext_mmu_wr_ack = (state_reg == WR_RESP);
   assign bus.o_ext_mmu_rd_ack = rd_ack_reg;
   assign bus.o_ext_mmu_rdat   = rdat_reg;
   assign bus.o_ext_mem_err    = err_reg;
endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: write/read bursts, masking, latency,
// arbitration, address wrap, protocol errors and reset mid-burst.
module tb_ext_mem_responder;
   localparam int PW = 34;
   localparam int DW = 128;
   localparam int MW = 16;
   localparam int RL = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;

   logic [DW-1:0] wbuf [4];
   logic [MW-1:0] mbuf [4];
   logic [DW-1:0] ebuf [4];
   logic [DW-1:0] d0, d1, d2, d3, d1m, xdat, ydat, w0, w1;

   ext_mem_responder_if #(.PADDR_WIDTH(PW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus_if ();

   ext_mem_responder #(
      .PADDR_WIDTH(PW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
      .DEPTH_LOG2(10), .RD_LATENCY(RL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      check_val("rst_rdy",    DW'(bus_if.o_ext_mmu_rdy),    DW'(1));
      check_val("rst_rd_ack", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      check_val("rst_wr_ack", DW'(bus_if.o_ext_mmu_wr_ack), DW'(0));
      check_val("rst_rdat",   bus_if.o_ext_mmu_rdat,        DW'(0));
      check_val("rst_err",    DW'(bus_if.o_ext_mem_err),    DW'(0));
      rst = 1'b0;
   endtask

   task automatic wait_rdy(input string tag);
      int guard = 0;
      while (!bus_if.o_ext_mmu_rdy && guard < 50) begin
         tick();
         guard++;
      end
      check_val(tag, DW'(bus_if.o_ext_mmu_rdy), DW'(1));
   endtask

   // Write burst of n beats from wbuf/mbuf; smask/emask give start/end per beat.
   task automatic wr_burst(input logic [PW-1:0] addr, input logic [2:0] code, input int n,
                           input logic [3:0] smask, input logic [3:0] emask, input bit stall);
      bus_if.i_mem_ext_wren  = 1'b1;
      bus_if.i_mem_ext_paddr = addr;
      bus_if.i_mem_ext_burst = code;
      wait_rdy("wr_accept");
      tick();
      bus_if.i_mem_ext_wren = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (stall && k == 1) begin
            bus_if.i_mem_ext_burst_vld = 1'b0;
            bus_if.i_mem_ext_wdat      = {4{32'hDEAD_BEEF}};
            tick();
         end
         bus_if.i_mem_ext_burst_vld   = 1'b1;
         bus_if.i_mem_ext_wdat        = wbuf[k];
         bus_if.i_mem_ext_mask        = mbuf[k];
         bus_if.i_mem_ext_burst_start = smask[k];
         bus_if.i_mem_ext_burst_end   = emask[k];
         check_val("wr_ack_mid", DW'(bus_if.o_ext_mmu_wr_ack), DW'(0));
         tick();
      end
      bus_if.i_mem_ext_burst_vld   = 1'b0;
      bus_if.i_mem_ext_burst_start = 1'b0;
      bus_if.i_mem_ext_burst_end   = 1'b0;
      check_val("wr_ack",       DW'(bus_if.o_ext_mmu_wr_ack), DW'(1));
      check_val("wr_no_rd_ack", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      check_val("wr_resp_rdy",  DW'(bus_if.o_ext_mmu_rdy),    DW'(0));
      tick();
      check_val("wr_ack_end",   DW'(bus_if.o_ext_mmu_wr_ack), DW'(0));
      check_val("wr_done_rdy",  DW'(bus_if.o_ext_mmu_rdy),    DW'(1));
      $display("cycle %0d: write burst addr=%h code=%0d beats=%0d", cyc, addr, code, n);
   endtask

   // Read burst of n beats; checks exact ack timing and data against ebuf.
   task automatic rd_burst(input logic [PW-1:0] addr, input logic [2:0] code, input int n);
      int t_acc;
      bus_if.i_mem_ext_rden  = 1'b1;
      bus_if.i_mem_ext_paddr = addr;
      bus_if.i_mem_ext_burst = code;
      wait_rdy("rd_accept");
      t_acc = cyc;
      tick();
      bus_if.i_mem_ext_rden = 1'b0;
      for (int i = 1; i < RL; i++) begin
         check_val("rd_wait_ack", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
         check_val("rd_wait_rdy", DW'(bus_if.o_ext_mmu_rdy),    DW'(0));
         tick();
      end
      for (int k = 0; k < n; k++) begin
         check_val("rd_ack",     DW'(bus_if.o_ext_mmu_rd_ack), DW'(1));
         check_val("rd_data",    bus_if.o_ext_mmu_rdat,        ebuf[k]);
         check_val("rd_beat_rdy", DW'(bus_if.o_ext_mmu_rdy),   DW'(0));
         check_val("rd_no_wr_ack", DW'(bus_if.o_ext_mmu_wr_ack), DW'(0));
         tick();
      end
      check_val("rd_ack_end",  DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      check_val("rd_rdat_end", bus_if.o_ext_mmu_rdat,        DW'(0));
      check_val("rd_done_rdy", DW'(bus_if.o_ext_mmu_rdy),    DW'(1));
      $display("cycle %0d: read burst addr=%h code=%0d beats=%0d accepted at cycle %0d", cyc, addr, code, n, t_acc);
   endtask

   initial begin
      int acks;
      int guard;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      bus_if.i_mem_ext_rden        = 1'b0;
      bus_if.i_mem_ext_wren        = 1'b0;
      bus_if.i_mem_ext_paddr       = '0;
      bus_if.i_mem_ext_burst       = 3'd1;
      bus_if.i_mem_ext_burst_vld   = 1'b0;
      bus_if.i_mem_ext_burst_start = 1'b0;
      bus_if.i_mem_ext_burst_end   = 1'b0;
      bus_if.i_mem_ext_mask        = '0;
      bus_if.i_mem_ext_wdat        = '0;
      apply_reset();

      // 1: single-beat write and read-back
      wbuf[0] = {16{8'hA5}};
      mbuf[0] = 16'hFFFF;
      wr_burst(34'h100, 3'd1, 1, 4'b0001, 4'b0001, 1'b0);
      ebuf[0] = {16{8'hA5}};
      rd_burst(34'h100, 3'd1, 1);
      check_val("t1_err", DW'(bus_if.o_ext_mem_err), DW'(0));

      // 2: four-beat write with a stall, masked overwrite of beat 1, read back
      d0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
      d1 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
      d2 = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
      d3 = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;
      wbuf[0] = d0; wbuf[1] = d1; wbuf[2] = d2; wbuf[3] = d3;
      for (int k = 0; k < 4; k++) mbuf[k] = 16'hFFFF;
      wr_burst(34'h200, 3'd4, 4, 4'b0001, 4'b1000, 1'b1);
      wbuf[0] = '1;
      mbuf[0] = 16'h00FF;
      wr_burst(34'h210, 3'd1, 1, 4'b0001, 4'b0001, 1'b0);
      d1m = d1;
      d1m[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      ebuf[0] = d0; ebuf[1] = d1m; ebuf[2] = d2; ebuf[3] = d3;
      // 3: four-beat read, timing checked beat by beat
      rd_burst(34'h200, 3'd4, 4);
      check_val("t2_err", DW'(bus_if.o_ext_mem_err), DW'(0));

      // 4: simultaneous read and write; write served first
      xdat = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
      bus_if.i_mem_ext_rden  = 1'b1;
      bus_if.i_mem_ext_wren  = 1'b1;
      bus_if.i_mem_ext_paddr = 34'h300;
      bus_if.i_mem_ext_burst = 3'd1;
      check_val("t4_rdy", DW'(bus_if.o_ext_mmu_rdy), DW'(1));
      tick();
      bus_if.i_mem_ext_wren        = 1'b0;
      check_val("t4_no_rd_ack0", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      check_val("t4_busy", DW'(bus_if.o_ext_mmu_rdy), DW'(0));
      bus_if.i_mem_ext_burst_vld   = 1'b1;
      bus_if.i_mem_ext_burst_start = 1'b1;
      bus_if.i_mem_ext_burst_end   = 1'b1;
      bus_if.i_mem_ext_mask        = 16'hFFFF;
      bus_if.i_mem_ext_wdat        = xdat;
      tick();
      bus_if.i_mem_ext_burst_vld   = 1'b0;
      bus_if.i_mem_ext_burst_start = 1'b0;
      bus_if.i_mem_ext_burst_end   = 1'b0;
      check_val("t4_wr_ack", DW'(bus_if.o_ext_mmu_wr_ack), DW'(1));
      check_val("t4_no_rd_ack1", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      tick();
      check_val("t4_rdy_again", DW'(bus_if.o_ext_mmu_rdy), DW'(1));
      check_val("t4_no_rd_ack2", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      tick();
      bus_if.i_mem_ext_rden = 1'b0;
      check_val("t4_rd_wait", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      tick();
      check_val("t4_rd_ack", DW'(bus_if.o_ext_mmu_rd_ack), DW'(1));
      check_val("t4_rd_data", bus_if.o_ext_mmu_rdat, xdat);
      tick();
      check_val("t4_rd_end", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      $display("cycle %0d: simultaneous rd/wr at 300 done", cyc);

      // 5: burst crossing the top entry wraps to entry 0
      w0 = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0000;
      w1 = 128'h5555_1111_5555_1111_5555_1111_5555_1111;
      wbuf[0] = w0; wbuf[1] = w1;
      mbuf[0] = 16'hFFFF; mbuf[1] = 16'hFFFF;
      wr_burst(34'h3FF0, 3'd2, 2, 4'b0001, 4'b0010, 1'b0);
      ebuf[0] = w1;
      rd_burst(34'h0, 3'd1, 1);
      rd_burst(34'h4000, 3'd1, 1);
      ebuf[0] = w0;
      rd_burst(34'h3FF8, 3'd1, 1);
      check_val("t5_err", DW'(bus_if.o_ext_mem_err), DW'(0));

      // 6a: burst_end asserted early on beat 1
      for (int k = 0; k < 4; k++) begin
         wbuf[k] = {4{32'(k + 32'h7000)}};
         mbuf[k] = 16'hFFFF;
      end
      wr_burst(34'h400, 3'd4, 4, 4'b0001, 4'b1010, 1'b0);
      check_val("t6a_err", DW'(bus_if.o_ext_mem_err), DW'(1));
      tick();
      check_val("t6a_err_sticky", DW'(bus_if.o_ext_mem_err), DW'(1));
      apply_reset();

      // 6b: burst code 0 runs a single beat and flags err
      ydat = 128'h0BAD_C0DE_0BAD_C0DE_0BAD_C0DE_0BAD_C0DE;
      wbuf[0] = ydat; mbuf[0] = 16'hFFFF;
      wr_burst(34'h500, 3'd0, 1, 4'b0001, 4'b0001, 1'b0);
      check_val("t6b_err", DW'(bus_if.o_ext_mem_err), DW'(1));
      ebuf[0] = ydat;
      rd_burst(34'h500, 3'd1, 1);
      ebuf[0] = d0; ebuf[1] = d1m; ebuf[2] = d2; ebuf[3] = d3;
      rd_burst(34'h200, 3'd5, 4);

      // 6c: reset while the read is returning beats
      bus_if.i_mem_ext_rden  = 1'b1;
      bus_if.i_mem_ext_paddr = 34'h200;
      bus_if.i_mem_ext_burst = 3'd4;
      wait_rdy("t6c_accept");
      tick();
      bus_if.i_mem_ext_rden = 1'b0;
      acks  = 0;
      guard = 0;
      while (guard < 20) begin
         if (bus_if.o_ext_mmu_rd_ack) acks++;
         if (acks == 2) break;
         tick();
         guard++;
      end
      check_val("t6c_two_acks", DW'(acks), DW'(2));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("t6c_rd_ack", DW'(bus_if.o_ext_mmu_rd_ack), DW'(0));
      check_val("t6c_rdat",   bus_if.o_ext_mmu_rdat,        DW'(0));
      check_val("t6c_rdy",    DW'(bus_if.o_ext_mmu_rdy),    DW'(1));
      check_val("t6c_err",    DW'(bus_if.o_ext_mem_err),    DW'(0));
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus_if.o_ext_mmu_rd_ack) acks++;
      end
      check_val("t6c_no_more_acks", DW'(acks), DW'(0));
      $display("cycle %0d: reset during read burst done", cyc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
